// File: rtl/aec_pkg.sv
// Shared definitions for the AEC expression transmitter: token layout,
// operator codes, ASCII character constants and the transmitter state enum.
package aec_pkg;

   localparam int TOK_W = 5;

   // Operator codes carried in tok[3:0] when tok[4] is set
   localparam logic [3:0] OP_LPAREN = 4'd0;
   localparam logic [3:0] OP_RPAREN = 4'd1;
   localparam logic [3:0] OP_MUL    = 4'd2;
   localparam logic [3:0] OP_ADD    = 4'd3;
   localparam logic [3:0] OP_SUB    = 4'd4;

   // ASCII characters understood by the calculator
   localparam logic [7:0] ASCII_DIGIT0 = 8'h30;
   localparam logic [7:0] ASCII_A      = 8'h61;
   localparam logic [7:0] ASCII_LPAREN = 8'h28;
   localparam logic [7:0] ASCII_RPAREN = 8'h29;
   localparam logic [7:0] ASCII_MUL    = 8'h2A;
   localparam logic [7:0] ASCII_ADD    = 8'h2B;
   localparam logic [7:0] ASCII_SUB    = 8'h2D;
   localparam logic [7:0] ASCII_EQ     = 8'h3D;
   localparam logic [7:0] ASCII_NUL    = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_TERM,
      ST_WAIT,
      ST_DONE
   } tx_state_t;

endpackage

// File: rtl/aec_tok2ascii.sv
// Combinational token-to-ASCII encoder. Unknown operator codes give NUL
// and raise invalid so the caller can drop the token.
module aec_tok2ascii
   import aec_pkg::*;
(
   input  logic [TOK_W-1:0] tok,
   output logic [7:0]       ascii,
   output logic             invalid
);

   // Operands map to lowercase hex digits, operators to their symbols
   always_comb begin
      ascii   = ASCII_NUL;
      invalid = 1'b0;
      if (!tok[4]) begin
         if (tok[3:0] < 4'd10) begin
            ascii = ASCII_DIGIT0 + {4'd0, tok[3:0]};
         end else begin
            ascii = ASCII_A + {4'd0, tok[3:0]} - 8'd10;
         end
      end else begin
         case (tok[3:0])
            OP_LPAREN: ascii = ASCII_LPAREN;
            OP_RPAREN: ascii = ASCII_RPAREN;
            OP_MUL:    ascii = ASCII_MUL;
            OP_ADD:    ascii = ASCII_ADD;
            OP_SUB:    ascii = ASCII_SUB;
            default:   invalid = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/aec_expr_tx.sv
// Expression transmitter: buffers host tokens, streams them as ASCII to the
// calculator terminated by '=', then returns the calculator's answer.
module aec_expr_tx
   import aec_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tok_valid,
   output logic             tok_ready,
   input  logic [TOK_W-1:0] tok_data,
   input  logic             send,
   output logic             ready,
   output logic [7:0]       ascii_out,
   input  logic             aec_valid,
   input  logic [6:0]       aec_result,
   input  logic             aec_legal,
   output logic             busy,
   output logic             done,
   output logic [6:0]       result,
   output logic             legal,
   output logic             err
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(TIMEOUT - 1);

   tx_state_t          state_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [CNT_W-1:0]   idx_reg;
   logic [WAIT_W-1:0]  wait_cnt_reg;
   logic [TOK_W-1:0]   tok_buf [DEPTH];

   logic [TOK_W-1:0]   rd_tok;
   logic [7:0]         rd_ascii;
   logic               rd_invalid;
   logic [7:0]         in_ascii;
   logic               in_invalid;
   logic               accept;
   logic               acc_ok;
   logic               acc_bad;
   logic               start;
   logic [CNT_W-1:0]   count_next;

   // With an empty buffer the first character comes straight from the
   // token being accepted in the same cycle as send.
   assign rd_tok = (state_reg == ST_IDLE && count_reg == '0)
                   ? tok_data : tok_buf[idx_reg[ADDR_W-1:0]];

   aec_tok2ascii u_rd_enc (
      .tok     (rd_tok),
      .ascii   (rd_ascii),
      .invalid (rd_invalid)
   );

   aec_tok2ascii u_in_enc (
      .tok     (tok_data),
      .ascii   (in_ascii),
      .invalid (in_invalid)
   );

   assign accept     = tok_valid && tok_ready;
   assign acc_ok     = accept && !in_invalid;
   assign acc_bad    = accept && in_invalid;
   assign count_next = count_reg + {{(CNT_W-1){1'b0}}, acc_ok};
   // An empty buffer only starts if the incoming first token is encodable
   assign start      = send && (count_reg != '0 || (accept && !rd_invalid));

   // Token storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (state_reg == ST_IDLE && acc_ok) begin
         tok_buf[count_reg[ADDR_W-1:0]] <= tok_data;
      end
   end

   // Transmit FSM with all host and calculator outputs registered
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         idx_reg      <= '0;
         wait_cnt_reg <= '0;
         tok_ready    <= 1'b1;
         ready        <= 1'b0;
         ascii_out    <= ASCII_NUL;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         legal        <= 1'b1;
         err          <= 1'b0;
      end else begin
         ready <= 1'b0;
         done  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               count_reg <= count_next;
               if (start) begin
                  state_reg <= ST_SEND;
                  idx_reg   <= CNT_W'(1);
                  ascii_out <= rd_ascii;
                  ready     <= 1'b1;
                  busy      <= 1'b1;
                  tok_ready <= 1'b0;
                  err       <= acc_bad;
               end else begin
                  tok_ready <= (count_next < DEPTH_C);
                  if (acc_bad) begin
                     err <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (idx_reg == count_reg) begin
                  ascii_out <= ASCII_EQ;
                  state_reg <= ST_TERM;
               end else begin
                  ascii_out <= rd_ascii;
                  idx_reg   <= idx_reg + CNT_W'(1);
               end
            end
            ST_TERM: begin
               ascii_out    <= ASCII_NUL;
               wait_cnt_reg <= '0;
               state_reg    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (aec_valid) begin
                  result    <= aec_result;
                  legal     <= aec_legal;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else if (wait_cnt_reg == WAIT_LAST_C) begin
                  result    <= '0;
                  legal     <= 1'b0;
                  err       <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            ST_DONE: begin
               count_reg <= '0;
               idx_reg   <= '0;
               busy      <= 1'b0;
               tok_ready <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // The input encoder's character is only needed for its invalid flag
   logic unused_in_ascii;
   assign unused_in_ascii = ^in_ascii;

endmodule

// File: tb/tb_aec_expr_tx.sv
// Scoreboard bench for aec_expr_tx: directed token sequences push expected
// characters and completions into a queue that a negedge monitor drains.
module tb_aec_expr_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tok_valid = 1'b0;
   logic [4:0] tok_data = 5'd0;
   logic       send = 1'b0;
   logic       aec_valid = 1'b0;
   logic [6:0] aec_result = 7'd0;
   logic       aec_legal = 1'b0;
   logic       tok_ready, ready, busy, done, legal, err;
   logic [7:0] ascii_out;
   logic [6:0] result;

   aec_expr_tx dut (
      .clk        (clk),
      .rst        (rst),
      .tok_valid  (tok_valid),
      .tok_ready  (tok_ready),
      .tok_data   (tok_data),
      .send       (send),
      .ready      (ready),
      .ascii_out  (ascii_out),
      .aec_valid  (aec_valid),
      .aec_result (aec_result),
      .aec_legal  (aec_legal),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .legal      (legal),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_done;
      logic [7:0] ch;
      logic       rdy;
      logic [6:0] res;
      logic       lg;
      logic       er;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;

   logic [7:0] hexc [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};

   // Monitor: every character and every done pulse is matched against the queue
   always @(negedge clk) begin
      if (mon_en) begin
         if (ascii_out != 8'h00) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL stream_char: got %02h ready=%0b, required nothing pending", ascii_out, ready);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_done || ascii_out !== mon_e.ch || ready !== mon_e.rdy) begin
                  n_bad++;
                  $display("FAIL stream_char: got %02h ready=%0b, required %02h ready=%0b (done_expected=%0b)",
                           ascii_out, ready, mon_e.ch, mon_e.rdy, mon_e.is_done);
               end
            end
         end
         if (done) begin
            n_cmp++;
            $display("txn done: result=%0d legal=%0b err=%0b", result, legal, err);
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL done_event: got unexpected done, required nothing pending");
            end else begin
               mon_e = exp_q.pop_front();
               if (!mon_e.is_done || result !== mon_e.res || legal !== mon_e.lg || err !== mon_e.er) begin
                  n_bad++;
                  $display("FAIL done_event: got result=%0d legal=%0b err=%0b, required result=%0d legal=%0b err=%0b (done_expected=%0b)",
                           result, legal, err, mon_e.res, mon_e.lg, mon_e.er, mon_e.is_done);
               end
            end
         end
         if (ready && ascii_out == 8'h00) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_idle: got ready=1 with ascii_out=00, required ready=0");
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic push_ch(input logic [7:0] c, input logic r);
      exp_t e;
      e.is_done = 1'b0; e.ch = c; e.rdy = r; e.res = 7'd0; e.lg = 1'b0; e.er = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic [6:0] r, input logic l, input logic e_flag);
      exp_t e;
      e.is_done = 1'b1; e.ch = 8'h00; e.rdy = 1'b0; e.res = r; e.lg = l; e.er = e_flag;
      exp_q.push_back(e);
   endtask

   // Present a token and hold it until the DUT accepts it
   task automatic send_tok(input logic [4:0] t);
      tok_valid = 1'b1;
      tok_data  = t;
      for (int i = 0; i < 50 && !tok_ready; i++) begin
         @(posedge clk); #1;
      end
      chk("tok_accept", tok_ready, 1);
      @(posedge clk); #1;
      tok_valid = 1'b0;
   endtask

   task automatic pulse_send();
      send = 1'b1;
      @(posedge clk); #1;
      send = 1'b0;
   endtask

   task automatic wait_eq();
      for (int i = 0; i < 100 && ascii_out !== 8'h3D; i++) begin
         @(posedge clk); #1;
      end
      chk("eq_seen", ascii_out, 8'h3D);
   endtask

   // Act as the calculator: answer a few cycles into WAIT
   task automatic run_calc(input logic [6:0] r, input logic l, input int dly);
      wait_eq();
      @(posedge clk); #1;
      for (int i = 0; i < dly; i++) begin
         @(posedge clk); #1;
      end
      aec_valid = 1'b1; aec_result = r; aec_legal = l;
      @(posedge clk); #1;
      aec_valid = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_result", result, r);
      chk("done_legal", legal, l);
      @(posedge clk); #1;
      chk("done_single", done, 0);
      chk("busy_fall", busy, 0);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk(nm, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_ready", ready, 0);
      chk("rst_ascii", ascii_out, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_legal", legal, 1);
      chk("rst_err", err, 0);
      chk("rst_tok_ready", tok_ready, 1);
      rst = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Basic: 3 + 4
      send_tok(5'h03); send_tok(5'h13); send_tok(5'h04);
      push_ch(8'h33, 1); push_ch(8'h2B, 0); push_ch(8'h34, 0); push_ch(8'h3D, 0);
      push_done(7'd7, 1, 0);
      pulse_send();
      chk("basic_first_ready", ready, 1);
      chk("basic_first_char", ascii_out, 8'h33);
      chk("basic_busy", busy, 1);
      chk("basic_tok_ready_busy", tok_ready, 0);
      run_calc(7'd7, 1, 2);
      drain("basic_drain");

      // Hex operands and parentheses
      send_tok(5'h10); send_tok(5'h0A); send_tok(5'h12); send_tok(5'h0F); send_tok(5'h11);
      push_ch(8'h28, 1); push_ch(8'h61, 0); push_ch(8'h2A, 0); push_ch(8'h66, 0);
      push_ch(8'h29, 0); push_ch(8'h3D, 0);
      push_done(7'd42, 1, 0);
      pulse_send();
      run_calc(7'd42, 1, 0);
      drain("hex_drain");

      // Full buffer, 17th token stalls
      for (int i = 0; i < 16; i++) send_tok(5'(i));
      tok_valid = 1'b1; tok_data = 5'h07;
      @(posedge clk); #1;
      chk("full_tok_ready", tok_ready, 0);
      tok_valid = 1'b0;
      for (int i = 0; i < 16; i++) push_ch(hexc[i], (i == 0));
      push_ch(8'h3D, 0);
      push_done(7'h55, 0, 0);
      pulse_send();
      run_calc(7'h55, 0, 3);
      drain("full_drain");

      // Eight tokens, ninth arrives together with send
      send_tok(5'h09); send_tok(5'h14); send_tok(5'h02); send_tok(5'h12);
      send_tok(5'h10); send_tok(5'h0B); send_tok(5'h13); send_tok(5'h0C);
      push_ch(8'h39, 1); push_ch(8'h2D, 0); push_ch(8'h32, 0); push_ch(8'h2A, 0);
      push_ch(8'h28, 0); push_ch(8'h62, 0); push_ch(8'h2B, 0); push_ch(8'h63, 0);
      push_ch(8'h29, 0); push_ch(8'h3D, 0);
      push_done(7'd3, 1, 0);
      tok_valid = 1'b1; tok_data = 5'h11; send = 1'b1;
      @(posedge clk); #1;
      tok_valid = 1'b0; send = 1'b0;
      chk("simul_first_ready", ready, 1);
      run_calc(7'd3, 1, 1);
      drain("simul_drain");

      // Send with an empty buffer is ignored
      pulse_send();
      chk("empty_busy", busy, 0);
      chk("empty_ascii", ascii_out, 8'h00);
      @(posedge clk); #1;
      chk("empty_busy_later", busy, 0);

      // Invalid token dropped, err set, cleared by the next start
      send_tok(5'h17);
      chk("invalid_err", err, 1);
      chk("invalid_tok_ready", tok_ready, 1);
      send_tok(5'h05); send_tok(5'h13); send_tok(5'h02);
      push_ch(8'h35, 1); push_ch(8'h2B, 0); push_ch(8'h32, 0); push_ch(8'h3D, 0);
      push_done(7'd7, 1, 0);
      pulse_send();
      chk("invalid_err_cleared", err, 0);
      run_calc(7'd7, 1, 1);
      drain("invalid_drain");

      // Timeout after 255 silent WAIT cycles
      send_tok(5'h01);
      push_ch(8'h31, 1); push_ch(8'h3D, 0);
      push_done(7'd0, 0, 1);
      pulse_send();
      wait_eq();
      for (int i = 0; i < 255; i++) begin
         @(posedge clk); #1;
      end
      chk("timeout_not_early", done, 0);
      @(posedge clk); #1;
      chk("timeout_done", done, 1);
      chk("timeout_result", result, 0);
      chk("timeout_legal", legal, 0);
      chk("timeout_err", err, 1);
      @(posedge clk); #1;
      chk("timeout_busy_fall", busy, 0);
      drain("timeout_drain");

      // Reset in the middle of SEND
      send_tok(5'h01); send_tok(5'h02); send_tok(5'h03); send_tok(5'h04);
      push_ch(8'h31, 1); push_ch(8'h32, 0); push_ch(8'h33, 0);
      pulse_send();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_third_char", ascii_out, 8'h33);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ready", ready, 0);
      chk("midrst_ascii", ascii_out, 8'h00);
      chk("midrst_busy", busy, 0);
      chk("midrst_legal", legal, 1);
      chk("midrst_err", err, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_tok_ready", tok_ready, 1);
      pulse_send();
      chk("midrst_empty_busy", busy, 0);
      drain("midrst_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
